// File: rtl/mem_disp_que_pkg.sv
// Shared types and sizing for the memory-side dispatch queue.
// microOp_t is the dispatch-stage micro-op as seen by memBlock.
package mem_disp_que_pkg;

  localparam int MEMDQ_DISP_WID = 4;
  localparam int MEMDQ_SIZE     = 16;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  lsq_idx;
    logic        is_store;
    logic [6:0]  rob_idx;
  } microOp_t;

endpackage

// File: rtl/mem_disp_que_if.sv
// Enqueue/present/dequeue bundle between dispatch, the queue and memory issue select.
// Handshake: an enqueue lane j transfers when i_enq_req[j] and o_can_enq are both high at
// the clock edge; a present lane k transfers when o_deq_vld[k] and i_deq_rdy[k] are both
// high. Both request vectors are contiguous prefixes from bit 0; o_can_enq and o_deq_vld
// never depend on the same-cycle request/ready inputs.
interface mem_disp_que_if
  import mem_disp_que_pkg::*;
#(
  parameter int DEPTH       = MEMDQ_SIZE,
  parameter int INPORT_NUM  = 4,
  parameter int OUTPORT_NUM = MEMDQ_DISP_WID
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic                                i_squash_vld;
  logic                                o_can_enq;
  logic [INPORT_NUM-1:0]               i_enq_req;
  microOp_t [INPORT_NUM-1:0]           i_enq_info;
  logic [OUTPORT_NUM-1:0]              o_deq_vld;
  microOp_t [OUTPORT_NUM-1:0]          o_deq_info;
  logic [OUTPORT_NUM-1:0]              i_deq_rdy;
  logic [CW-1:0]                       o_count;

  modport master (
    output i_squash_vld, i_enq_req, i_enq_info, i_deq_rdy,
    input  o_can_enq, o_deq_vld, o_deq_info, o_count
  );

  modport slave (
    input  i_squash_vld, i_enq_req, i_enq_info, i_deq_rdy,
    output o_can_enq, o_deq_vld, o_deq_info, o_count
  );

endinterface

// File: rtl/mem_disp_que_count_one.sv
// Population count of a request vector; used for enqueue and dequeue lane counts.
module count_one #(
  parameter  int W  = 4,
  localparam int OW = $clog2(W) + 1
) (
  input  logic [W-1:0]  bits,
  output logic [OW-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/mem_disp_que.sv
// In-order circular dispatch queue for load/store micro-ops feeding memory issue select.
// Pointers carry a wrap bit so full and empty are distinguishable without extra state.
module mem_disp_que
  import mem_disp_que_pkg::*;
#(
  parameter int DEPTH       = MEMDQ_SIZE,
  parameter int INPORT_NUM  = 4,
  parameter int OUTPORT_NUM = MEMDQ_DISP_WID
) (
  input logic           clk,
  input logic           rst,
  mem_disp_que_if.slave io
);

  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = IW + 1;
  localparam int CW  = IW + 1;
  localparam int EW  = $clog2(INPORT_NUM) + 1;
  localparam int DW  = $clog2(OUTPORT_NUM) + 1;
  localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - INPORT_NUM);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  microOp_t      storage [DEPTH];

  logic                   can_enq;
  logic                   full;
  logic                   empty;
  logic [INPORT_NUM-1:0]  enq_mask;
  logic [OUTPORT_NUM-1:0] deq_vld;
  logic [OUTPORT_NUM-1:0] deq_mask;
  logic [EW-1:0]          n_enq;
  logic [DW-1:0]          n_deq;
  logic [PW-1:0]          head_nxt;
  logic [PW-1:0]          tail_nxt;
  logic [CW-1:0]          count_nxt;

  // Credit is taken from the registered count only, so this cycle's pops never help.
  assign can_enq = (count <= ENQ_LIMIT);
  assign full    = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign empty   = (head == tail);

  assign enq_mask = io.i_enq_req & {INPORT_NUM{can_enq}};
  assign deq_mask = io.i_deq_rdy & deq_vld;

  count_one #(.W(INPORT_NUM)) u_enq_cnt (
    .bits (enq_mask),
    .ones (n_enq)
  );

  count_one #(.W(OUTPORT_NUM)) u_deq_cnt (
    .bits (deq_mask),
    .ones (n_deq)
  );

  assign head_nxt  = head + PW'(n_deq);
  assign tail_nxt  = tail + PW'(n_enq);
  assign count_nxt = count + CW'(n_enq) - CW'(n_deq);

  always_comb begin
    deq_vld = '0;
    for (int k = 0; k < OUTPORT_NUM; k++) begin
      deq_vld[k] = (CW'(k) < count);
    end
  end

  always_comb begin
    logic [IW-1:0] rd_idx;
    io.o_deq_info = '0;
    for (int k = 0; k < OUTPORT_NUM; k++) begin
      rd_idx           = head[IW-1:0] + IW'(k);
      io.o_deq_info[k] = storage[rd_idx];
    end
  end

  assign io.o_deq_vld = deq_vld;
  assign io.o_can_enq = can_enq;
  assign io.o_count   = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (io.i_squash_vld) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  // Payload is never reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    if (!io.i_squash_vld) begin
      for (int j = 0; j < INPORT_NUM; j++) begin
        if (enq_mask[j]) begin
          storage[tail[IW-1:0] + IW'(j)] <= io.i_enq_info[j];
        end
      end
    end
  end

  a_enq_prefix : assert property (@(posedge clk) disable iff (!rst)
    ((io.i_enq_req & (io.i_enq_req + INPORT_NUM'(1))) == '0));

  a_deq_prefix : assert property (@(posedge clk) disable iff (!rst)
    ((io.i_deq_rdy & (io.i_deq_rdy + OUTPORT_NUM'(1))) == '0));

  a_deq_subset : assert property (@(posedge clk) disable iff (!rst)
    ((io.i_deq_rdy & ~deq_vld) == '0));

  a_count_max : assert property (@(posedge clk) disable iff (!rst)
    (count <= CW'(DEPTH)));

  a_count_ptrs : assert property (@(posedge clk) disable iff (!rst)
    (count == CW'(tail - head)));

  a_no_enq_full : assert property (@(posedge clk) disable iff (!rst)
    !(full && (|enq_mask)));

  a_empty_cnt : assert property (@(posedge clk) disable iff (!rst)
    (empty == (count == '0)));

endmodule

// File: tb/tb_mem_disp_que.sv
// Directed bench for mem_disp_que: a queue model checked every negedge plus literal pins.
module tb_mem_disp_que;
  import mem_disp_que_pkg::*;

  localparam int DEPTH = 16;
  localparam int NIN   = 4;
  localparam int NOUT  = 4;

  logic clk;
  logic rst;

  mem_disp_que_if #(.DEPTH(DEPTH), .INPORT_NUM(NIN), .OUTPORT_NUM(NOUT)) bus ();

  mem_disp_que #(.DEPTH(DEPTH), .INPORT_NUM(NIN), .OUTPORT_NUM(NOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int n_cmp;
  int n_err;
  microOp_t exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic microOp_t mk_uop(input int v);
    microOp_t u;
    u          = '0;
    u.rob_idx  = 7'(v);
    u.is_store = v[0];
    u.lsq_idx  = 5'(v * 3);
    u.imm      = 32'(v * 1001);
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of stimulus starting just after a posedge
  task automatic step(input logic [3:0] req, input int base, input logic [3:0] rdy, input logic sq);
    for (int j = 0; j < NIN; j++) bus.i_enq_info[j] = mk_uop(base + j);
    bus.i_enq_req    = req;
    bus.i_deq_rdy    = rdy;
    bus.i_squash_vld = sq;
    @(posedge clk);
    #1;
    bus.i_enq_req    = '0;
    bus.i_deq_rdy    = '0;
    bus.i_squash_vld = 1'b0;
  endtask

  // model: an ordered list of live entries
  always @(posedge clk or negedge rst) begin
    int sz;
    int n_pop;
    if (!rst) begin
      exp_q.delete();
    end else if (bus.i_squash_vld) begin
      exp_q.delete();
    end else begin
      sz    = exp_q.size();
      n_pop = 0;
      for (int k = 0; k < NOUT; k++) if (bus.i_deq_rdy[k] && k < sz) n_pop++;
      for (int k = 0; k < n_pop; k++) void'(exp_q.pop_front());
      if ((DEPTH - sz) >= NIN) begin
        for (int j = 0; j < NIN; j++) if (bus.i_enq_req[j]) exp_q.push_back(bus.i_enq_info[j]);
      end
    end
  end

  // scoreboard compare every cycle
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = '0;
    for (int k = 0; k < NOUT; k++) ev[k] = (k < exp_q.size());
    check("count", 64'(bus.o_count), 64'(exp_q.size()));
    check("can_enq", 64'(bus.o_can_enq), 64'((DEPTH - exp_q.size()) >= NIN));
    check("deq_vld", 64'(bus.o_deq_vld), 64'(ev));
    for (int k = 0; k < NOUT; k++) begin
      if (k < exp_q.size()) check("deq_info", 64'(bus.o_deq_info[k]), 64'(exp_q[k]));
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst              = 1'b0;
    bus.i_enq_req    = '0;
    bus.i_deq_rdy    = '0;
    bus.i_squash_vld = 1'b0;
    for (int j = 0; j < NIN; j++) bus.i_enq_info[j] = '0;
    #1;
    check("rst_count", 64'(bus.o_count), 64'd0);
    check("rst_vld", 64'(bus.o_deq_vld), 64'd0);
    check("rst_can_enq", 64'(bus.o_can_enq), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // first burst: visible next cycle
    step(4'b1111, 0, 4'b0000, 1'b0);
    check("b1_vld", 64'(bus.o_deq_vld), 64'hF);
    check("b1_count", 64'(bus.o_count), 64'd4);
    for (int k = 0; k < NOUT; k++) check("b1_rob", 64'(bus.o_deq_info[k].rob_idx), 64'(k));

    // fill
    step(4'b1111, 4, 4'b0000, 1'b0);
    step(4'b1111, 8, 4'b0000, 1'b0);
    check("c12_can_enq", 64'(bus.o_can_enq), 64'd1);
    step(4'b0001, 12, 4'b0000, 1'b0);
    check("c13_count", 64'(bus.o_count), 64'd13);
    check("c13_can_enq", 64'(bus.o_can_enq), 64'd0);
    step(4'b1111, 50, 4'b0000, 1'b0);
    check("c13_hold", 64'(bus.o_count), 64'd13);
    step(4'b0000, 0, 4'b0001, 1'b0);
    check("c12_pop", 64'(bus.o_count), 64'd12);
    step(4'b1111, 13, 4'b0000, 1'b0);
    check("full_count", 64'(bus.o_count), 64'd16);
    check("full_can_enq", 64'(bus.o_can_enq), 64'd0);
    step(4'b1111, 100, 4'b0000, 1'b0);
    check("full_hold", 64'(bus.o_count), 64'd16);
    for (int k = 0; k < NOUT; k++) check("full_rob", 64'(bus.o_deq_info[k].rob_idx), 64'(k + 1));

    // squash at count 8 with enq+deq in flight
    step(4'b0000, 0, 4'b1111, 1'b0);
    step(4'b0000, 0, 4'b1111, 1'b0);
    check("c8_count", 64'(bus.o_count), 64'd8);
    step(4'b1111, 30, 4'b0011, 1'b1);
    check("sq_count", 64'(bus.o_count), 64'd0);
    check("sq_vld", 64'(bus.o_deq_vld), 64'd0);
    check("sq_can_enq", 64'(bus.o_can_enq), 64'd1);

    // build head=14, count=2
    for (int b = 0; b < 4; b++) step(4'b1111, 40 + 4 * b, 4'b0000, 1'b0);
    for (int b = 0; b < 3; b++) step(4'b0000, 0, 4'b1111, 1'b0);
    check("h12_rob", 64'(bus.o_deq_info[0].rob_idx), 64'd52);
    step(4'b0000, 0, 4'b0011, 1'b0);
    check("h14_count", 64'(bus.o_count), 64'd2);
    check("h14_rob", 64'(bus.o_deq_info[0].rob_idx), 64'd54);

    // wrap: enqueue into storage 0..3 while popping the last two
    step(4'b1111, 20, 4'b0011, 1'b0);
    check("wrap_count", 64'(bus.o_count), 64'd4);
    for (int k = 0; k < NOUT; k++) check("wrap_rob", 64'(bus.o_deq_info[k].rob_idx), 64'(20 + k));

    // partial accept
    step(4'b0000, 0, 4'b0011, 1'b0);
    check("part_count", 64'(bus.o_count), 64'd2);
    check("part_rob", 64'(bus.o_deq_info[0].rob_idx), 64'd22);
    check("part_vld", 64'(bus.o_deq_vld), 64'h3);

    // async reset mid-burst at count 10
    step(4'b1111, 60, 4'b0000, 1'b0);
    step(4'b1111, 64, 4'b0000, 1'b0);
    check("c10_count", 64'(bus.o_count), 64'd10);
    for (int j = 0; j < NIN; j++) bus.i_enq_info[j] = mk_uop(70 + j);
    bus.i_enq_req = 4'b1111;
    bus.i_deq_rdy = 4'b1111;
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(bus.o_count), 64'd0);
    check("arst_vld", 64'(bus.o_deq_vld), 64'd0);
    bus.i_enq_req = '0;
    bus.i_deq_rdy = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(4'b0001, 90, 4'b0000, 1'b0);
    check("post_vld", 64'(bus.o_deq_vld), 64'h1);
    check("post_rob", 64'(bus.o_deq_info[0].rob_idx), 64'd90);
    check("post_count", 64'(bus.o_count), 64'd1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_disp_que.md
# mem_disp_que

Memory-side dispatch queue between rename/dispatch and `memBlock`. It buffers load/store micro-ops in program order as a circular FIFO. Each cycle it presents up to `OUTPORT_NUM` oldest entries to the memory issue-queue selection logic and pops the in-order prefix that logic accepts. A pipeline squash empties it.

## Interface
- `DEPTH`, default 16: entry count; must be a power of 2 and ≥ `INPORT_NUM`.
- `INPORT_NUM`, default 4: enqueue ports per cycle.
- `OUTPORT_NUM`, default `MEMDQ_DISP_WID`: dequeue/present ports per cycle; must be ≤ `DEPTH`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_squash_vld`  in  1  flush all entries.
- `o_can_enq`  out  1  at least `INPORT_NUM` free entries (from registered count).
- `i_enq_req`  in  `INPORT_NUM`  enqueue valids; must be a contiguous prefix from bit 0.
- `i_enq_info`  in  `microOp_t[INPORT_NUM]`  enqueued micro-ops.
- `o_deq_vld`  out  `OUTPORT_NUM`  bit k set when entry head+k exists.
- `o_deq_info`  out  `microOp_t[OUTPORT_NUM]`  entry at head+k.
- `i_deq_rdy`  in  `OUTPORT_NUM`  consumer accepts; must be a contiguous prefix that is a subset of `o_deq_vld`.
- `o_count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- State: `head` and `tail` pointers, each `$clog2(DEPTH)` bits plus a wrap bit; `count` register; `DEPTH` × `microOp_t` storage.
- Full when the pointer indices are equal and the wrap bits differ. Empty when the pointers are fully equal. `count` equals `tail - head` as a wrap-inclusive subtraction.
- Enqueue fires only when `o_can_enq` is 1. It is all-or-nothing per cycle. Port j writes `storage[tail+j]`. `tail` advances by popcount(`i_enq_req`).
- Enqueue requested while `o_can_enq` is 0 is ignored; no state changes. The producer must hold the request.
- Present: `o_deq_vld[k] = (k < count)`. `o_deq_info[k] = storage[head+k]`, mod `DEPTH`. `o_deq_info` is don't-care where `o_deq_vld` is 0.
- Dequeue: `head` advances by popcount(`i_deq_rdy & o_deq_vld`).
- Update rule: `count_next = count + n_enq - n_deq`. Enqueue and dequeue in the same cycle are both honoured.
- `o_can_enq = (DEPTH - count) >= INPORT_NUM`. It uses the registered count only; same-cycle dequeues give no credit.
- Squash: `head`, `tail` and `count` go to 0 next cycle. Squash overrides any enqueue or dequeue in the same cycle. Storage contents are not cleared.
- Pointer arithmetic wraps modulo 2·`DEPTH`, with the index taken mod `DEPTH`. There is no special case at the wrap.
- Assertions:
  - `i_enq_req` is a prefix.
  - `i_deq_rdy` is a prefix and a subset of `o_deq_vld`.
  - `count` ≤ `DEPTH`.
  - No enqueue accepted while full.

## Timing
- Reset, asynchronous while `rst` is 0: `head`, `tail`, `count` are 0. Resulting outputs:
  - `o_deq_vld` = 0.
  - `o_count` = 0.
  - `o_can_enq` = 1.
- An entry enqueued in cycle t is visible on `o_deq_vld` and `o_deq_info` in t+1. Minimum latency is 1 cycle.
- `o_deq_vld`, `o_deq_info`, `o_count` and `o_can_enq` are combinational from registers only. They have no combinational path from `i_deq_rdy`, `i_enq_req` or `i_squash_vld`.
- A pop takes effect at the clock edge of the cycle in which `i_deq_rdy` is asserted.
- Reset asserted mid-operation clears state immediately and asynchronously. The first valid enqueue is the first edge after `rst` deasserts.

## Structure
- Shared package: `microOp_t` (existing), `MEMDQ_DISP_WID`, `MEMDQ_SIZE`.
- Sub-module: reuse the existing `count_one` for the enqueue and dequeue popcounts.
- No other hierarchy; storage is plain flops.

## Test plan
- Reset, then enqueue 4 uops with rob_idx 0–3 in cycle 1; `i_deq_rdy` = 0.
  - Cycle 2: `o_deq_vld` = 4'b1111, `o_deq_info[k].rob_idx` = k, `o_count` = 4.
- Fill to 16 with `i_deq_rdy` = 0.
  - `o_can_enq` drops to 0 at count 13.
  - An enqueue attempted at count 16 leaves `o_count` at 16 and the contents unchanged.
- Wrap-around: with head = 14, count = 2, enqueue 4 uops with rob_idx 20–23 and pop 2 in the same cycle.
  - Next cycle: `o_count` = 4; `o_deq_info[0..3].rob_idx` = 20–23, read from storage 0–3.
- Partial accept: count = 4, `i_deq_rdy` = 4'b0011.
  - Next cycle: count = 2, and `o_deq_info[0]` is the former entry 2.
- Squash with a simultaneous enqueue of 4 and dequeue of 2 at count 8.
  - Next cycle: `o_count` = 0, `o_deq_vld` = 0, `o_can_enq` = 1.
- Assert `rst` low asynchronously mid-burst at count 10.
  - `o_count` = 0 and `o_deq_vld` = 0 without waiting for a clock edge.
  - After release, an enqueue of 1 gives `o_deq_vld` = 4'b0001 one cycle later.
